// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch sequencer.
// Holds the 2-bit FSM state encoding and the default bus width.
// Imported by fetch_unit.
package fetch_unit_pkg;

  // IDLE samples the PC, REQ holds the memory read, HOLD presents the word.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_t;

  localparam int FETCH_DEFAULT_BUS_WIDTH = 16;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer between the PC, instruction memory and decoder.
// Latency: 3 cycles per instruction minimum (IDLE, REQ, HOLD); +1 per memory wait or decoder stall cycle.
// Backpressure: holds the instruction in HOLD until instr_ready or jump; the memory request is held until mem_ready.
//
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   pc_value                current PC from the program counter
//   pc_inc/pc_load/pc_in    PC controls, combinational, consumed at the same edge
//   mem_req/mem_addr        registered read request; address stable while requested
//   mem_ready/mem_data      memory response strobe and read data
//   instr_valid/instr       registered instruction register and its valid flag
//   instr_ready             decoder accepts the instruction
//   jump/jump_target        single-cycle redirect strobe and target address
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int BUS_WIDTH = FETCH_DEFAULT_BUS_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [BUS_WIDTH-1:0] pc_value,
  output logic                 pc_inc,
  output logic                 pc_load,
  output logic [BUS_WIDTH-1:0] pc_in,
  output logic                 mem_req,
  output logic [BUS_WIDTH-1:0] mem_addr,
  input  logic                 mem_ready,
  input  logic [BUS_WIDTH-1:0] mem_data,
  output logic                 instr_valid,
  output logic [BUS_WIDTH-1:0] instr,
  input  logic                 instr_ready,
  input  logic                 jump,
  input  logic [BUS_WIDTH-1:0] jump_target
);

  fetch_state_t         r_state;
  fetch_state_t         w_next_state;
  logic [BUS_WIDTH-1:0] r_addr;
  logic [BUS_WIDTH-1:0] r_instr;
  logic                 r_flush;

  // Response handling in REQ. A response is only kept if no redirect has
  // been seen since the request went out (r_flush) and none arrives with it.
  logic w_in_req;
  logic w_accept;
  logic w_discard;
  logic w_defer_flush;

  always_comb begin
    w_in_req      = (r_state == ST_REQ);
    w_accept      = w_in_req &  mem_ready & ~jump & ~r_flush;
    w_discard     = w_in_req &  mem_ready & (jump | r_flush);
    // The read cannot be withdrawn, so a redirect during a wait is remembered
    // and the stale word is dropped when it finally arrives.
    w_defer_flush = w_in_req & ~mem_ready & jump;
  end

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        // A jump here loads the PC at this edge; staying in IDLE lets the
        // next sample pick up the new PC value.
        if (jump) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_REQ;
        end
      end
      ST_REQ: begin
        if (w_accept) begin
          w_next_state = ST_HOLD;
        end else if (w_discard) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_REQ;
        end
      end
      ST_HOLD: begin
        // A jump retires the held instruction even without instr_ready.
        if (jump || instr_ready) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_HOLD;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    mem_req     = (r_state == ST_REQ);
    mem_addr    = r_addr;
    instr_valid = (r_state == ST_HOLD);
    instr       = r_instr;
    // pc_inc is suppressed whenever jump is high, so the two strobes never
    // overlap and the redirect always wins at the PC.
    pc_inc      = w_accept;
    pc_load     = jump;
    pc_in       = jump_target;
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  // Fetch address: sampled from the PC only while idle, so mem_addr stays
  // put for the whole request even if the PC is loaded underneath it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_addr <= '0;
    end else if (r_state == ST_IDLE) begin
      r_addr <= pc_value;
    end
  end

  // Instruction register: written only on an accepted response.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_instr <= '0;
    end else if (w_accept) begin
      r_instr <= mem_data;
    end
  end

  // Flush flag: set by a redirect while waiting, cleared when the
  // outstanding response is consumed (kept or dropped).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_flush <= 1'b0;
    end else if (w_in_req && mem_ready) begin
      r_flush <= 1'b0;
    end else if (w_defer_flush) begin
      r_flush <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clock;
  logic        reset;
  logic [15:0] pc_value;
  logic        pc_inc;
  logic        pc_load;
  logic [15:0] pc_in;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ready;
  logic [15:0] mem_data;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic        jump;
  logic [15:0] jump_target;

  logic [15:0] pc_init;
  int          errors;
  int          checks;

  fetch_unit #(.BUS_WIDTH(16)) dut (
    .clock       (clock),
    .reset       (reset),
    .pc_value    (pc_value),
    .pc_inc      (pc_inc),
    .pc_load     (pc_load),
    .pc_in       (pc_in),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ready   (mem_ready),
    .mem_data    (mem_data),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .jump        (jump),
    .jump_target (jump_target)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Program counter that sits next to the fetch unit in the real system.
  always @(posedge clock or posedge reset) begin
    if (reset)        pc_value <= pc_init;
    else if (pc_load) pc_value <= pc_in;
    else if (pc_inc)  pc_value <= pc_value + 16'd1;
  end

  // Instruction memory contents as a fixed function of the address.
  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    logic [15:0] p;
    p = a * 16'h9E37;
    return p ^ 16'h5A5A;
  endfunction

  // Leaves the bench at a falling edge with reset just released (DUT in IDLE).
  task automatic do_reset(input logic [15:0] init);
    reset = 1'b1;
    pc_init = init;
    mem_ready = 1'b0;
    mem_data = 16'h0;
    instr_ready = 1'b0;
    jump = 1'b0;
    jump_target = 16'h0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pc_init = 16'h0;
    mem_ready = 1'b1;
    mem_data = 16'hFFFF;
    instr_ready = 1'b1;
    jump = 1'b0;
    jump_target = 16'hABCD;
    @(negedge clock);
    #1;
    checks++;
    if (mem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 16'h0 || mem_addr !== 16'h0)
      $display("FAIL reset_outputs: req=%b valid=%b instr=%h addr=%h, required 0/0/0000/0000",
               mem_req, instr_valid, instr, mem_addr);
    checks++;
    if (pc_inc !== 1'b0 || pc_load !== 1'b0)
      $display("FAIL reset_pc_ctrl: inc=%b load=%b, required 0/0", pc_inc, pc_load);
    checks++;
    if (pc_in !== 16'hABCD)
      $display("FAIL reset_pc_in: got %h, required abcd", pc_in);
    errors += (mem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 16'h0 || mem_addr !== 16'h0) ? 1 : 0;
    errors += (pc_inc !== 1'b0 || pc_load !== 1'b0) ? 1 : 0;
    errors += (pc_in !== 16'hABCD) ? 1 : 0;
  endtask

  task automatic test_basic();
    int incs;
    incs = 0;
    do_reset(16'h0);
    mem_ready = 1'b1;
    mem_data = 16'h1234;
    instr_ready = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++; $display("FAIL basic_idle_noreq: req=%b, required 0", mem_req);
    end
    @(negedge clock);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0) begin
      errors++; $display("FAIL basic_first_req: req=%b addr=%h, required 1/0000", mem_req, mem_addr);
    end
    if (pc_inc === 1'b1) incs++;
    @(negedge clock);
    checks++;
    if (instr_valid !== 1'b1 || instr !== 16'h1234 || mem_req !== 1'b0) begin
      errors++; $display("FAIL basic_instr: valid=%b instr=%h req=%b, required 1/1234/0", instr_valid, instr, mem_req);
    end
    if (pc_inc === 1'b1) incs++;
    @(negedge clock);
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++; $display("FAIL basic_consumed: valid=%b, required 0", instr_valid);
    end
    checks++;
    if (incs != 1 || pc_value !== 16'd1) begin
      errors++; $display("FAIL basic_pc_inc: pulses=%0d pc=%h, required 1/0001", incs, pc_value);
    end
  endtask

  task automatic test_mem_wait();
    int req_cycles;
    int incs;
    bit got;
    req_cycles = 0; incs = 0; got = 0;
    do_reset(16'd5);
    mem_data = 16'hBEEF;
    instr_ready = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clock);
      mem_ready = 1'b0;
      if (instr_valid === 1'b1) begin
        got = 1;
      end else if (mem_req === 1'b1) begin
        req_cycles++;
        checks++;
        if (mem_addr !== 16'd5) begin
          errors++; $display("FAIL wait_addr_stable: addr=%h in REQ cycle %0d, required 0005", mem_addr, req_cycles);
        end
        if (req_cycles == 3) mem_ready = 1'b1;
      end
      #1;
      if (pc_inc === 1'b1) incs++;
    end
    checks++;
    if (!got || instr !== 16'hBEEF) begin
      errors++; $display("FAIL wait_instr: seen=%0d instr=%h, required 1/beef", got, instr);
    end
    checks++;
    if (req_cycles != 3 || incs != 1) begin
      errors++; $display("FAIL wait_counts: req_cycles=%0d inc_pulses=%0d, required 3/1", req_cycles, incs);
    end
  endtask

  task automatic test_stall();
    bit got;
    got = 0;
    do_reset(16'd7);
    mem_ready = 1'b1;
    mem_data = 16'h7777;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clock);
      if (instr_valid === 1'b1) got = 1;
    end
    checks++;
    if (!got) begin
      errors++; $display("FAIL stall_reach_hold: instr_valid never rose, required 1");
    end
    mem_data = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clock);
      #1;
      checks++;
      if (instr_valid !== 1'b1 || instr !== 16'h7777 || mem_req !== 1'b0 || pc_inc !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold_%0d: valid=%b instr=%h req=%b inc=%b, required 1/7777/0/0",
                 i, instr_valid, instr, mem_req, pc_inc);
      end
    end
    instr_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++; $display("FAIL stall_release: valid=%b, required 0", instr_valid);
    end
  endtask

  task automatic test_jump_hold();
    bit got;
    got = 0;
    do_reset(16'd3);
    mem_ready = 1'b1;
    mem_data = 16'h3333;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clock);
      if (instr_valid === 1'b1) got = 1;
    end
    jump = 1'b1;
    jump_target = 16'd511;
    #1;
    checks++;
    if (!got || pc_load !== 1'b1 || pc_inc !== 1'b0 || pc_in !== 16'd511) begin
      errors++;
      $display("FAIL jhold_strobe: hold=%0d load=%b inc=%b pc_in=%h, required 1/1/0/01ff", got, pc_load, pc_inc, pc_in);
    end
    @(negedge clock);
    jump = 1'b0;
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++; $display("FAIL jhold_valid_drop: valid=%b, required 0", instr_valid);
    end
    @(negedge clock);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 16'd511) begin
      errors++; $display("FAIL jhold_next_addr: req=%b addr=%h, required 1/01ff", mem_req, mem_addr);
    end
  endtask

  task automatic test_jump_req_wait();
    int incs;
    incs = 0;
    do_reset(16'd10);
    mem_data = 16'hDEAD;
    @(negedge clock);
    jump = 1'b1;
    jump_target = 16'd4;
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 16'd10 || pc_load !== 1'b1) begin
      errors++; $display("FAIL jreq_strobe: req=%b addr=%h load=%b, required 1/000a/1", mem_req, mem_addr, pc_load);
    end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      jump = 1'b0;
      mem_ready = (k == 3);
      #1;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 16'd10) begin
        errors++; $display("FAIL jreq_held_%0d: req=%b addr=%h, required 1/000a", k, mem_req, mem_addr);
      end
      if (pc_inc === 1'b1) incs++;
    end
    @(negedge clock);
    #1;
    if (pc_inc === 1'b1) incs++;
    checks++;
    if (instr_valid !== 1'b0 || mem_req !== 1'b0 || incs != 0) begin
      errors++; $display("FAIL jreq_discard: valid=%b req=%b inc_pulses=%0d, required 0/0/0", instr_valid, mem_req, incs);
    end
    @(negedge clock);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 16'd4) begin
      errors++; $display("FAIL jreq_next_addr: req=%b addr=%h, required 1/0004", mem_req, mem_addr);
    end
  endtask

  task automatic test_jump_same_cycle();
    do_reset(16'd20);
    mem_ready = 1'b1;
    mem_data = 16'h2020;
    instr_ready = 1'b1;
    @(negedge clock);
    jump = 1'b1;
    jump_target = 16'd8;
    #1;
    checks++;
    if (mem_req !== 1'b1 || pc_load !== 1'b1 || pc_inc !== 1'b0) begin
      errors++; $display("FAIL jsame_strobe: req=%b load=%b inc=%b, required 1/1/0", mem_req, pc_load, pc_inc);
    end
    @(negedge clock);
    jump = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL jsame_discard: valid=%b req=%b, required 0/0", instr_valid, mem_req);
    end
    @(negedge clock);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 16'd8) begin
      errors++; $display("FAIL jsame_next_addr: req=%b addr=%h, required 1/0008", mem_req, mem_addr);
    end
  endtask

  task automatic test_async_reset();
    do_reset(16'd9);
    @(negedge clock);
    checks++;
    if (mem_req !== 1'b1) begin
      errors++; $display("FAIL areset_pre: req=%b, required 1", mem_req);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || mem_addr !== 16'h0) begin
      errors++; $display("FAIL areset_drop: req=%b addr=%h, required 0/0000", mem_req, mem_addr);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Random traffic against a transaction-level model: the fetched address
  // stream is "last jump target, then +1 per delivered instruction", a
  // response is kept only if no jump occurred during its request, and a
  // kept word is presented until the decoder takes it or a jump retires it.
  task automatic test_random();
    logic [15:0] exp_addr, req_addr, held_val, prev_addr;
    bit          hold, tainted, prev_req, prev_ready, pending, exp_inc;
    int          wt, delivered;
    hold = 0; tainted = 0; prev_req = 0; prev_ready = 0; pending = 0;
    wt = 0; delivered = 0; held_val = 16'h0; req_addr = 16'h0; prev_addr = 16'h0;
    exp_addr = 16'($urandom);
    do_reset(exp_addr);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clock);
      checks++;
      if (instr_valid !== hold || (hold && instr !== held_val)) begin
        errors++;
        $display("FAIL rnd_instr cyc %0d: valid=%b instr=%h, required %b/%h", cyc, instr_valid, instr, hold, held_val);
      end
      if (mem_req === 1'b1 && !prev_req) begin
        req_addr = exp_addr;
        checks++;
        if (mem_addr !== exp_addr || hold) begin
          errors++; $display("FAIL rnd_req_addr cyc %0d: addr=%h hold=%b, required %h/0", cyc, mem_addr, hold, exp_addr);
        end
      end
      if (prev_req && !prev_ready) begin
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== prev_addr) begin
          errors++; $display("FAIL rnd_req_held cyc %0d: req=%b addr=%h, required 1/%h", cyc, mem_req, mem_addr, prev_addr);
        end
      end
      jump = ($urandom_range(0, 19) == 0);
      jump_target = 16'($urandom);
      instr_ready = ($urandom_range(0, 3) != 0);
      mem_ready = 1'b0;
      mem_data = 16'($urandom);
      if (mem_req === 1'b1) begin
        if (!pending) begin
          pending = 1;
          wt = $urandom_range(0, 3);
        end
        if (wt == 0) begin
          mem_ready = 1'b1;
          mem_data = mem_fn(mem_addr);
          pending = 0;
        end else begin
          wt--;
        end
      end else begin
        pending = 0;
      end
      #1;
      exp_inc = (mem_req === 1'b1) && mem_ready && !jump && !tainted;
      checks++;
      if (pc_inc !== exp_inc || pc_load !== jump || pc_in !== jump_target) begin
        errors++;
        $display("FAIL rnd_pc_ctrl cyc %0d: inc=%b load=%b in=%h, required %b/%b/%h",
                 cyc, pc_inc, pc_load, pc_in, exp_inc, jump, jump_target);
      end
      if (hold && (jump || instr_ready)) hold = 0;
      if (exp_inc) begin
        hold = 1;
        held_val = mem_fn(req_addr);
        exp_addr = req_addr + 16'd1;
        delivered++;
      end
      if (mem_req === 1'b1 && mem_ready) tainted = 0;
      else if (mem_req === 1'b1 && jump) tainted = 1;
      if (jump) exp_addr = jump_target;
      prev_req = (mem_req === 1'b1);
      prev_addr = mem_addr;
      prev_ready = mem_ready;
    end
    checks++;
    if (delivered < 100) begin
      errors++; $display("FAIL rnd_progress: delivered=%0d, required >= 100", delivered);
    end
    jump = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    pc_init = 16'h0;
    mem_ready = 1'b0;
    mem_data = 16'h0;
    instr_ready = 1'b0;
    jump = 1'b0;
    jump_target = 16'h0;
    test_reset();
    test_basic();
    test_mem_wait();
    test_stall();
    test_jump_hold();
    test_jump_req_wait();
    test_jump_same_cycle();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
